// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encodings and polarity-applied one-hot decode helper
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // One output bit of the decode. An out-of-range select leaves every bit
    // inactive. opt=0 drives the selected bit low, opt=1 drives it high.
    function automatic logic onehot_bit(
        input int unsigned sel,
        input int unsigned num_out,
        input int unsigned pos,
        input logic        opt
    );
        logic active;
        active = (sel < num_out) && (sel == pos);
        return active ~^ opt;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational select to one-hot decode with polarity and range blanking
//   sel : index to decode (values >= NUM_OUT give an all-inactive vector)
//   opt : polarity, 0 = selected bit low, 1 = selected bit high
//   y   : decoded vector
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               opt,
    output logic [NUM_OUT-1:0] y
);

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_bit
        assign y[i] = onehot_bit(32'(sel), 32'(NUM_OUT), 32'(i), opt);
    end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot select decoder with manual and auto-scan modes
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_en           : block enable, low forces idle with blank output
//   i_mode         : 0 = manual decode of i_sel, 1 = auto scan
//   i_sel          : manual-mode select
//   i_opt          : output polarity, 0 = selected bit low
//   i_period       : scan dwell cycles per position (0 behaves as 1)
//   o_y            : registered decoded output
//   o_idx          : index currently driven
//   o_wrap         : one-cycle pulse on the first cycle of index 0 after a scan wrap
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W        = 3,
    parameter int NUM_OUT      = 8,
    parameter int PER_W        = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_mode,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic               i_opt,
    input  logic [PER_W-1:0]   i_period,
    output logic [NUM_OUT-1:0] o_y,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_wrap
);

    localparam int BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLK_M1 = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

    state_t             state;
    logic [PER_W-1:0]   dwell_cnt;
    logic [BLK_W-1:0]   blank_cnt;
    // Set while a scan run is in progress; clear means the next scan-mode
    // cycle starts a fresh run at index 0 (entry from idle or from manual).
    logic               scan_act;

    logic [SEL_W-1:0]   idx_inc;
    logic [PER_W-1:0]   period_m1;
    logic [NUM_OUT-1:0] blank_val;
    logic [NUM_OUT-1:0] dec_sel;
    logic [NUM_OUT-1:0] dec_cur;
    logic [NUM_OUT-1:0] dec_inc;
    logic [NUM_OUT-1:0] dec_zero;

    assign idx_inc   = (o_idx == LAST_IDX) ? '0 : o_idx + 1'b1;
    assign period_m1 = (i_period == '0) ? '0 : i_period - 1'b1;
    assign blank_val = {NUM_OUT{~i_opt}};

    decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec_sel (
        .sel (i_sel), .opt (i_opt), .y (dec_sel)
    );
    decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec_cur (
        .sel (o_idx), .opt (i_opt), .y (dec_cur)
    );
    decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec_inc (
        .sel (idx_inc), .opt (i_opt), .y (dec_inc)
    );
    decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec_zero (
        .sel ('0), .opt (i_opt), .y (dec_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_y       <= '1;
            o_idx     <= '0;
            o_wrap    <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            scan_act  <= 1'b0;
        end else if (!i_en) begin
            state     <= ST_IDLE;
            o_y       <= blank_val;
            o_idx     <= '0;
            o_wrap    <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            scan_act  <= 1'b0;
        end else if (!i_mode) begin
            // Manual decode; any scan dwell or blank in progress is dropped.
            state     <= ST_SHOW;
            o_y       <= dec_sel;
            o_idx     <= i_sel;
            o_wrap    <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            scan_act  <= 1'b0;
        end else if (!scan_act) begin
            state     <= ST_SHOW;
            o_y       <= dec_zero;
            o_idx     <= '0;
            o_wrap    <= 1'b0;
            dwell_cnt <= period_m1;
            blank_cnt <= '0;
            scan_act  <= 1'b1;
        end else begin
            o_wrap <= 1'b0;
            case (state)
                ST_SHOW: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                        o_y       <= dec_cur;
                    end else if (BLANK_CYCLES > 0) begin
                        state     <= ST_BLANK;
                        blank_cnt <= BLK_W'(BLK_M1);
                        o_y       <= blank_val;
                    end else begin
                        o_idx     <= idx_inc;
                        o_y       <= dec_inc;
                        o_wrap    <= (o_idx == LAST_IDX);
                        dwell_cnt <= period_m1;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt != '0) begin
                        blank_cnt <= blank_cnt - 1'b1;
                        o_y       <= blank_val;
                    end else begin
                        state     <= ST_SHOW;
                        o_idx     <= idx_inc;
                        o_y       <= dec_inc;
                        o_wrap    <= (o_idx == LAST_IDX);
                        dwell_cnt <= period_m1;
                    end
                end
                default: begin
                    state     <= ST_SHOW;
                    o_y       <= dec_zero;
                    o_idx     <= '0;
                    dwell_cnt <= period_m1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed self-checking bench for decoder_scan
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic        opt;
    logic [15:0] period;

    logic [7:0]  y8;
    logic [2:0]  idx8;
    logic        wrap8;
    logic [5:0]  y6;
    logic [2:0]  idx6;
    logic        wrap6;
    logic [7:0]  y0;
    logic [2:0]  idx0;
    logic        wrap0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .NUM_OUT(8), .PER_W(16), .BLANK_CYCLES(2)) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_en (en), .i_mode (mode),
        .i_sel (sel), .i_opt (opt), .i_period (period),
        .o_y (y8), .o_idx (idx8), .o_wrap (wrap8)
    );

    decoder_scan #(.SEL_W(3), .NUM_OUT(6), .PER_W(16), .BLANK_CYCLES(2)) dut6 (
        .i_clk (clk), .i_rst_n (rst_n), .i_en (en), .i_mode (mode),
        .i_sel (sel), .i_opt (opt), .i_period (period),
        .o_y (y6), .o_idx (idx6), .o_wrap (wrap6)
    );

    decoder_scan #(.SEL_W(3), .NUM_OUT(8), .PER_W(16), .BLANK_CYCLES(0)) dut0 (
        .i_clk (clk), .i_rst_n (rst_n), .i_en (en), .i_mode (mode),
        .i_sel (sel), .i_opt (opt), .i_period (period),
        .o_y (y0), .o_idx (idx0), .o_wrap (wrap0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp8;
        int pos;

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; opt = 1'b0; period = 16'd4;
        tick();
        tick();
        check("reset_y",    {24'h0, y8},   32'hFF);
        check("reset_idx",  {29'h0, idx8}, 32'h0);
        check("reset_wrap", {31'h0, wrap8}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_y", {24'h0, y8}, 32'hFF);

        // Manual decode and polarity
        en = 1'b1; mode = 1'b0; sel = 3'd3; opt = 1'b0;
        tick();
        check("man_y_sel3",   {24'h0, y8},   32'hF7);
        check("man_idx_sel3", {29'h0, idx8}, 32'h3);
        opt = 1'b1;
        tick();
        check("man_y_opt1", {24'h0, y8}, 32'h08);

        // Out of range on the 6-output instance
        sel = 3'd7; opt = 1'b0;
        tick();
        check("oor6_y",   {26'h0, y6},   32'h3F);
        check("oor6_idx", {29'h0, idx6}, 32'h7);
        check("sel7_y8",  {24'h0, y8},   32'h7F);

        // Scan, period 4, two blank cycles: 6 cycles per position
        mode = 1'b1; period = 16'd4;
        for (int t = 0; t < 80; t++) begin
            tick();
            pos  = (t / 6) % 8;
            exp8 = ((t % 6) < 4) ? ~(8'd1 << pos) : 8'hFF;
            check($sformatf("scan_y_t%0d", t), {24'h0, y8}, {24'h0, exp8});
            check($sformatf("scan_idx_t%0d", t), {29'h0, idx8}, 32'(pos));
            check($sformatf("scan_wrap_t%0d", t), {31'h0, wrap8}, (t == 48) ? 32'h1 : 32'h0);
        end
        // t=79 is the second dwell cycle of index 5
        en = 1'b0;
        tick();
        check("abort_y",    {24'h0, y8},   32'hFF);
        check("abort_idx",  {29'h0, idx8}, 32'h0);
        check("abort_wrap", {31'h0, wrap8}, 32'h0);
        en = 1'b1;
        tick();
        check("reen_y",    {24'h0, y8},   32'hFE);
        check("reen_idx",  {29'h0, idx8}, 32'h0);
        check("reen_wrap", {31'h0, wrap8}, 32'h0);
        mode = 1'b0; sel = 3'd2;
        tick();
        check("to_man_y",   {24'h0, y8},   32'hFB);
        check("to_man_idx", {29'h0, idx8}, 32'h2);

        // Period 0 with no blanking: one position per cycle
        mode = 1'b1; period = 16'd0;
        for (int t = 0; t < 17; t++) begin
            tick();
            exp8 = ~(8'd1 << (t % 8));
            check($sformatf("p0_y_t%0d", t), {24'h0, y0}, {24'h0, exp8});
            check($sformatf("p0_wrap_t%0d", t), {31'h0, wrap0},
                  (t == 8 || t == 16) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset mid-scan takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y",    {24'h0, y8},   32'hFF);
        check("arst_idx",  {29'h0, idx8}, 32'h0);
        check("arst_wrap", {31'h0, wrap8}, 32'h0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_y", {24'h0, y8}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
